ysyx_2022040010_pipe_ctrl: RTL and testbench

- Central stall/flush/redirect controller for the 5-stage in-order RV64 pipeline (IF, ID, EX, MEM, WB).
- Collects stall requests from ID (load-use), EX (multi-cycle mul/div) and the IF/MEM AXI ports. Collects branch redirects from EX and traps (ecall/mret/ebreak) from WB.
- Drives one StallBus to every pipeline register, one flush vector, and the PC redirect. An FSM defers redirects until outstanding AXI transactions drain, and provides halt and AXI-timeout detection.

---
 rtl/ysyx_2022040010_pipe_ctrl_pkg.sv | 55 +++++
 rtl/ysyx_2022040010_pipe_ctrl_if.sv | 35 +++
 rtl/ysyx_2022040010_axi_watchdog.sv | 33 +++
 rtl/ysyx_2022040010_pipe_ctrl.sv | 117 +++++++++++
 tb/tb_ysyx_2022040010_pipe_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_2022040010_pipe_ctrl_pkg.sv
// Shared StallBus/flush layout, FSM encoding and the hazard priority encoder for the pipeline controller.
// Pure types and functions, no timing of its own.
package ysyx_2022040010_pipe_ctrl_pkg;

   localparam int XLEN    = 64;
   localparam int STALL_W = 6;
   localparam int FLUSH_W = 5;

   localparam int STALL_PC    = 0;
   localparam int STALL_IFID  = 1;
   localparam int STALL_IDEX  = 2;
   localparam int STALL_EXMEM = 3;
   localparam int STALL_MEMWB = 4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [STALL_W-1:0] stall;
      logic [FLUSH_W-1:0] flush;
   } ctrl_t;

   // Bits [top:0] set; the reserved top bit is never set.
   function automatic logic [STALL_W-1:0] stall_prefix(input int top);
      logic [STALL_W-1:0] m;
      m = '0;
      for (int i = 0; i < STALL_W - 1; i++) m[i] = (i <= top);
      return m;
   endfunction

   // Deepest stalled stage wins; a bubble goes only into the register just past it.
   function automatic ctrl_t hazard_ctrl(input logic mem_busy, input logic ex_req,
                                         input logic id_req, input logic if_busy);
      ctrl_t c;
      c = '0;
      if (mem_busy) begin
         c.stall = stall_prefix(STALL_MEMWB);
      end else if (ex_req) begin
         c.stall = stall_prefix(STALL_EXMEM);
         c.flush[STALL_MEMWB] = 1'b1;
      end else if (id_req) begin
         c.stall = stall_prefix(STALL_IDEX);
         c.flush[STALL_EXMEM] = 1'b1;
      end else if (if_busy) begin
         c.stall = stall_prefix(STALL_IFID);
         c.flush[STALL_IDEX] = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/ysyx_2022040010_pipe_ctrl_if.sv
// Pipeline <-> controller bundle: hazard/redirect requests in, StallBus/flush/redirect out.
interface ysyx_2022040010_pipe_ctrl_if #(parameter int CNT_W = 64);
   import ysyx_2022040010_pipe_ctrl_pkg::*;

   logic               stallreq_id;
   logic               stallreq_ex;
   logic               if_axi_busy;
   logic               mem_axi_busy;
   logic               br_valid;
   logic [XLEN-1:0]    br_target;
   logic               trap_valid;
   logic [XLEN-1:0]    trap_target;
   logic               ebreak_valid;

   logic [STALL_W-1:0] stall;
   logic [FLUSH_W-1:0] flush;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               halted;
   logic               axi_timeout;
   logic [CNT_W-1:0]   stall_cycles;

   modport master (
      output stallreq_id, stallreq_ex, if_axi_busy, mem_axi_busy,
             br_valid, br_target, trap_valid, trap_target, ebreak_valid,
      input  stall, flush, redirect_valid, redirect_pc, halted, axi_timeout, stall_cycles
   );

   modport slave (
      input  stallreq_id, stallreq_ex, if_axi_busy, mem_axi_busy,
             br_valid, br_target, trap_valid, trap_target, ebreak_valid,
      output stall, flush, redirect_valid, redirect_pc, halted, axi_timeout, stall_cycles
   );

endinterface

// File: rtl/ysyx_2022040010_axi_watchdog.sv
// Counts consecutive cycles with any AXI port busy; raises a sticky timeout on the TIMEOUT_CYC-th one.
// Observation only: never stalls or alters the pipeline.
module ysyx_2022040010_axi_watchdog #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic if_busy,
   input  logic mem_busy,
   output logic timeout
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic          busy;
   logic [CW-1:0] cnt;
   logic          at_limit;

   assign busy     = if_busy | mem_busy;
   assign at_limit = (cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         if (!busy)         cnt <= '0;
         else if (!at_limit) cnt <= cnt + CW'(1);
         if (busy && at_limit) timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Stall/flush/redirect controller: stalls are combinational from requests and FSM state; redirects
// fire one cycle after the request, or one cycle after both AXI ports go idle when a drain is needed.
module ysyx_2022040010_pipe_ctrl
   import ysyx_2022040010_pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 64
) (
   input logic                       clk,
   input logic                       rst,
   ysyx_2022040010_pipe_ctrl_if.slave bus
);

   state_t             state, state_n;
   logic [XLEN-1:0]    pend_pc, pend_pc_n;
   logic               pend_br, pend_br_n;
   logic [CNT_W-1:0]   sc_q;

   logic [STALL_W-1:0] stall_c;
   logic [FLUSH_W-1:0] flush_c;
   logic               rvld_c;
   logic [XLEN-1:0]    rpc_c;
   logic               any_busy;
   logic               br_take;
   ctrl_t              hz, hz_br;

   assign any_busy = bus.if_axi_busy | bus.mem_axi_busy;
   assign br_take  = bus.br_valid & ~bus.stallreq_ex & ~bus.mem_axi_busy;
   assign hz       = hazard_ctrl(bus.mem_axi_busy, bus.stallreq_ex, bus.stallreq_id, bus.if_axi_busy);
   // A draining branch keeps the front end frozen as if the fetch were still outstanding.
   assign hz_br    = hazard_ctrl(bus.mem_axi_busy, bus.stallreq_ex, bus.stallreq_id, 1'b1);

   always_comb begin
      state_n   = state;
      pend_pc_n = pend_pc;
      pend_br_n = pend_br;
      stall_c   = '0;
      flush_c   = '0;
      rvld_c    = 1'b0;
      rpc_c     = '0;
      case (state)
         ST_RUN: begin
            stall_c = hz.stall;
            flush_c = hz.flush;
            if (bus.ebreak_valid) begin
               state_n = ST_HALT;
            end else if (bus.trap_valid) begin
               pend_pc_n = bus.trap_target;
               pend_br_n = 1'b0;
               state_n   = any_busy ? ST_DRAIN : ST_FLUSH;
            end else if (br_take) begin
               pend_pc_n = bus.br_target;
               pend_br_n = 1'b1;
               state_n   = bus.if_axi_busy ? ST_DRAIN : ST_FLUSH;
            end
         end
         ST_DRAIN: begin
            if (pend_br) begin
               stall_c = hz_br.stall;
               flush_c = hz_br.flush;
            end else begin
               stall_c = stall_prefix(STALL_MEMWB);
            end
            if (bus.trap_valid) begin
               pend_pc_n = bus.trap_target;
               pend_br_n = 1'b0;
            end
            if (!any_busy) state_n = ST_FLUSH;
         end
         ST_FLUSH: begin
            rvld_c = 1'b1;
            rpc_c  = pend_pc;
            flush_c[STALL_IFID] = 1'b1;
            flush_c[STALL_IDEX] = 1'b1;
            if (!pend_br) begin
               flush_c[STALL_EXMEM] = 1'b1;
               flush_c[STALL_MEMWB] = 1'b1;
            end
            state_n = ST_RUN;
         end
         ST_HALT: begin
            stall_c = stall_prefix(STALL_MEMWB);
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         pend_pc <= '0;
         pend_br <= 1'b0;
         sc_q    <= '0;
      end else begin
         state   <= state_n;
         pend_pc <= pend_pc_n;
         pend_br <= pend_br_n;
         if (stall_c[STALL_PC]) sc_q <= sc_q + CNT_W'(1);
      end
   end

   ysyx_2022040010_axi_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .if_busy  (bus.if_axi_busy),
      .mem_busy (bus.mem_axi_busy),
      .timeout  (bus.axi_timeout)
   );

   assign bus.stall          = stall_c;
   assign bus.flush          = flush_c;
   assign bus.redirect_valid = rvld_c;
   assign bus.redirect_pc    = rpc_c;
   assign bus.halted         = (state == ST_HALT);
   assign bus.stall_cycles   = sc_q;

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
// Directed bench for the pipeline controller: hazard table in RUN plus drain/flush/halt/watchdog sequences.
module tb_ysyx_2022040010_pipe_ctrl;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ysyx_2022040010_pipe_ctrl_if #(.CNT_W(64)) bus ();

   ysyx_2022040010_pipe_ctrl #(.TIMEOUT_CYC(16), .CNT_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "bench timeout");
   end

   typedef struct {
      logic       id;
      logic       ex;
      logic       ifb;
      logic       mem;
      logic [5:0] st;
      logic [4:0] fl;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.stallreq_id  = 1'b0;
      bus.stallreq_ex  = 1'b0;
      bus.if_axi_busy  = 1'b0;
      bus.mem_axi_busy = 1'b0;
      bus.br_valid     = 1'b0;
      bus.br_target    = '0;
      bus.trap_valid   = 1'b0;
      bus.trap_target  = '0;
      bus.ebreak_valid = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 5'b00000};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 5'b01000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001111, 5'b10000};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000011, 5'b00100};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111, 5'b00000};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b001111, 5'b10000};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b000111, 5'b01000};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b011111, 5'b00000};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111, 5'b10000};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111, 5'b00000};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b011111, 5'b00000};

      clr_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #2;
      chk("rst_stall", bus.stall, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_rvld", bus.redirect_valid, 0);
      chk("rst_rpc", bus.redirect_pc, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_timeout", bus.axi_timeout, 0);
      chk("rst_sc", bus.stall_cycles, 0);

      // Hazard priority table, one cycle per vector.
      for (int i = 0; i < 11; i++) begin
         bus.stallreq_id  = vecs[i].id;
         bus.stallreq_ex  = vecs[i].ex;
         bus.if_axi_busy  = vecs[i].ifb;
         bus.mem_axi_busy = vecs[i].mem;
         #2;
         chk($sformatf("vec%0d_stall", i), bus.stall, vecs[i].st);
         chk($sformatf("vec%0d_flush", i), bus.flush, vecs[i].fl);
         tick();
      end
      clr_in();
      #2;
      chk("table_sc", bus.stall_cycles, 10);

      // Single-cycle load-use then release.
      do_reset();
      bus.stallreq_id = 1'b1;
      #2;
      chk("ld_use_stall", bus.stall, 6'b000111);
      chk("ld_use_flush", bus.flush, 5'b01000);
      tick();
      bus.stallreq_id = 1'b0;
      #2;
      chk("ld_use_rel_stall", bus.stall, 0);
      chk("ld_use_rel_flush", bus.flush, 0);

      // MEM busy and load-use together for three cycles.
      do_reset();
      bus.mem_axi_busy = 1'b1;
      bus.stallreq_id  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("memid%0d_stall", i), bus.stall, 6'b011111);
         chk($sformatf("memid%0d_flush", i), bus.flush, 0);
         tick();
      end
      clr_in();
      #2;
      chk("memid_sc", bus.stall_cycles, 3);

      // Branch while fetch outstanding: drain, then redirect; a DRAIN-time branch is ignored.
      do_reset();
      bus.br_valid = 1'b1; bus.br_target = 64'h8000_0100; bus.if_axi_busy = 1'b1;
      #2;
      chk("br_run_stall", bus.stall, 6'b000011);
      chk("br_run_flush", bus.flush, 5'b00100);
      tick();
      bus.br_target = 64'h0000_dead;
      #2;
      chk("br_drain1_stall", bus.stall, 6'b000011);
      chk("br_drain1_flush", bus.flush, 5'b00100);
      chk("br_drain1_rvld", bus.redirect_valid, 0);
      tick();
      clr_in();
      #2;
      chk("br_drain2_stall", bus.stall, 6'b000011);
      chk("br_drain2_rvld", bus.redirect_valid, 0);
      tick();
      #2;
      chk("br_flush_rvld", bus.redirect_valid, 1);
      chk("br_flush_rpc", bus.redirect_pc, 64'h8000_0100);
      chk("br_flush_flush", bus.flush, 5'b00110);
      chk("br_flush_stall", bus.stall, 0);
      tick();
      #2;
      chk("br_back_rvld", bus.redirect_valid, 0);
      chk("br_back_stall", bus.stall, 0);

      // Trap and branch in the same cycle: trap wins, branch is dropped.
      bus.trap_valid = 1'b1; bus.trap_target = 64'h8000_0004;
      bus.br_valid = 1'b1;   bus.br_target = 64'h8000_0200;
      tick();
      clr_in();
      #2;
      chk("tb_rvld", bus.redirect_valid, 1);
      chk("tb_rpc", bus.redirect_pc, 64'h8000_0004);
      chk("tb_flush", bus.flush, 5'b11110);
      chk("tb_stall", bus.stall, 0);
      tick();
      #2;
      chk("tb_after1_rvld", bus.redirect_valid, 0);
      tick();
      #2;
      chk("tb_after2_rvld", bus.redirect_valid, 0);

      // Trap arriving during a branch drain replaces the pending branch.
      bus.br_valid = 1'b1; bus.br_target = 64'h8000_0300; bus.if_axi_busy = 1'b1;
      tick();
      bus.br_valid = 1'b0; bus.trap_valid = 1'b1; bus.trap_target = 64'h8000_0008;
      #2;
      chk("ovr_brdrain_stall", bus.stall, 6'b000011);
      tick();
      clr_in();
      #2;
      chk("ovr_trdrain_stall", bus.stall, 6'b011111);
      chk("ovr_trdrain_flush", bus.flush, 0);
      tick();
      #2;
      chk("ovr_rvld", bus.redirect_valid, 1);
      chk("ovr_rpc", bus.redirect_pc, 64'h8000_0008);
      chk("ovr_flush", bus.flush, 5'b11110);
      tick();

      // Trap behind an outstanding MEM access.
      bus.trap_valid = 1'b1; bus.trap_target = 64'h8000_0010; bus.mem_axi_busy = 1'b1;
      tick();
      bus.trap_valid = 1'b0;
      #2;
      chk("trmem_drain_stall", bus.stall, 6'b011111);
      chk("trmem_drain_rvld", bus.redirect_valid, 0);
      tick();
      bus.mem_axi_busy = 1'b0;
      #2;
      chk("trmem_last_rvld", bus.redirect_valid, 0);
      tick();
      #2;
      chk("trmem_rvld", bus.redirect_valid, 1);
      chk("trmem_rpc", bus.redirect_pc, 64'h8000_0010);
      tick();

      // Reset while draining discards the pending branch.
      bus.br_valid = 1'b1; bus.br_target = 64'h8000_0400; bus.if_axi_busy = 1'b1;
      tick();
      bus.br_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.if_axi_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("rstdrain%0d_rvld", i), bus.redirect_valid, 0);
         chk($sformatf("rstdrain%0d_stall", i), bus.stall, 0);
         tick();
      end

      // Watchdog: 15 busy cycles is under the limit, 16 trips it and it stays set.
      do_reset();
      bus.if_axi_busy = 1'b1;
      repeat (15) tick();
      bus.if_axi_busy = 1'b0;
      tick();
      #2;
      chk("wd15_timeout", bus.axi_timeout, 0);
      bus.if_axi_busy = 1'b1;
      repeat (15) tick();
      #2;
      chk("wd16_pre_timeout", bus.axi_timeout, 0);
      tick();
      #2;
      chk("wd16_timeout", bus.axi_timeout, 1);
      bus.if_axi_busy = 1'b0;
      repeat (3) tick();
      #2;
      chk("wd_sticky", bus.axi_timeout, 1);
      chk("wd_stall_free", bus.stall, 0);

      // ebreak halts; traps are ignored while halted; only reset leaves HALT.
      do_reset();
      bus.ebreak_valid = 1'b1;
      tick();
      bus.ebreak_valid = 1'b0;
      bus.trap_valid = 1'b1; bus.trap_target = 64'h0000_1234;
      for (int i = 0; i < 100; i++) begin
         #2;
         chk($sformatf("halt%0d_halted", i), bus.halted, 1);
         chk($sformatf("halt%0d_stall", i), bus.stall, 6'b011111);
         if (i == 0) begin
            chk("halt_flush", bus.flush, 0);
            chk("halt_rvld", bus.redirect_valid, 0);
         end
         tick();
      end
      clr_in();
      #2;
      chk("halt_end_halted", bus.halted, 1);
      chk("halt_sc", bus.stall_cycles, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("unhalt_halted", bus.halted, 0);
      chk("unhalt_stall", bus.stall, 0);
      chk("unhalt_sc", bus.stall_cycles, 0);
      chk("unhalt_rvld", bus.redirect_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
